spi_master: RTL and testbench
=============================

# spi_master

Single-clock SPI master (initiator) that shifts one fixed-width frame out on `mosi` while capturing `miso`, generating `sclk` and `ss` from the system clock. It is the host-side counterpart of the SPI-to-APB bridge slave in the GPIO expander. It drives bridge transactions in system-level benches and in the host FPGA image. SPI mode 0 only: CPOL=0, CPHA=0, MSB first.

## Interface
- `FRAME_WIDTH`, 16: bits per frame (bridge format: bit15 R/W, bits14:8 address, bits7:0 data).
- `CLK_DIV`, 2: system clocks per `sclk` half-period. Minimum 1.
- `clk` in 1: system clock; all logic on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: request a frame; accepted only when `ready`=1.
- `tx_data` in FRAME_WIDTH: frame to send; latched on the accepting edge.
- `ready` out 1: idle and able to accept `start`.
- `done` out 1: one-cycle pulse when the frame completes.
- `rx_data` out FRAME_WIDTH: captured `miso` frame; valid from `done` until the next `done`.
- `sclk` out 1: SPI clock; idle low.
- `ss` out 1: active-low slave select.
- `mosi` out 1: serial data out.
- `miso` in 1: serial data in; treated as synchronous to `sclk`, with no synchroniser.

## Operation
- **Reset values:** `ready`=1, `done`=0, `rx_data`=0, `sclk`=0, `ss`=1, `mosi`=0, state IDLE. Reset applies immediately, including mid-frame; the aborted frame produces no `done`.
- **FSM states:** IDLE, SETUP, HIGH, LOW, HOLD, GAP. A divider counter (0..CLK_DIV-1) times each state; "expiry" means the counter reaches CLK_DIV-1.
- **IDLE:** when `start` and `ready` are both 1, on that edge:
  - latch `tx_data` into the tx shift register;
  - set `ss`=0 and `mosi`=tx_data[MSB];
  - set `ready`=0, clear the bit counter, go to SETUP.
- **SETUP:** on expiry, set `sclk`=1, sample `miso` into the rx shift register (`rx <= {rx[FW-2:0], miso}`), go to HIGH.
- **HIGH:** on expiry, set `sclk`=0 and increment the bit counter.
  - If this was the last bit (counter was FRAME_WIDTH-1), go to HOLD.
  - Otherwise shift tx, drive `mosi` with the next bit, go to LOW.
- **LOW:** on expiry, set `sclk`=1, sample `miso`, go to HIGH.
- **HOLD:** on expiry, set `ss`=1 and `mosi`=0, copy the rx shift register to `rx_data`, pulse `done`, go to GAP.
- **GAP:** `ss` stays high for CLK_DIV cycles; on expiry set `ready`=1 and go to IDLE.
- **Ignored inputs:** `start` while `ready`=0 is dropped, with no queueing. `tx_data` changes after acceptance have no effect.
- **Bit counter width:** $clog2(FRAME_WIDTH)+1; no wrap within a frame.

## Timing
- Edge 0 is the accepting edge. Counting from edge 0:
  - first `sclk` rise at CLK_DIV;
  - exactly FRAME_WIDTH rising edges per frame;
  - `done` at (2*FRAME_WIDTH+1)*CLK_DIV; this is 66 cycles for the defaults;
  - `ready` returns CLK_DIV cycles after `done`.
- `mosi` changes only with `sclk` falling, or at `ss` assertion for bit 0. Setup and hold to the `sclk` rise are each ≥CLK_DIV system clocks.
- `miso` is sampled on the system edge that raises `sclk`. The slave must present each bit by the preceding `sclk` fall; for bit 0, by `ss` falling.
- `ss` leads the first `sclk` rise by CLK_DIV, and trails the last `sclk` fall by CLK_DIV.
- Minimum `ss`-high time between frames is CLK_DIV+1 cycles (GAP, plus the accepting IDLE cycle).
- `start` may be held high continuously; back-to-back frames then follow at the minimum gap.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `spi_pkg`:
  - FSM state enum localparams (IDLE..GAP);
  - default FRAME_WIDTH;
  - bridge frame field positions (RW_BIT=15, ADDR_MSB=14, ADDR_LSB=8, DATA_MSB=7).
- One sub-module, `spi_clk_div`: divider counter producing the `expire` tick, cleared on every state change.
- Target size: roughly 150-250 lines of RTL.

## Test plan
- **Loopback** (`miso` tied to `mosi`), send 16'hA5C3 → `rx_data`=16'hA5C3, `done` exactly 66 cycles after acceptance, 16 `sclk` rises counted.
- **`miso` tied 0**, send 16'hFFFF → `rx_data`=16'h0000; `mosi` is 1 at all 16 `sclk` rises.
- **Slave model** returning 16'h3C5A MSB-first, changing on `sclk` fall → `rx_data`=16'h3C5A; a checker sees no `mosi` change within CLK_DIV of any `sclk` rise.
- **`start` pulsed at cycle 10 of a busy frame** → ignored; exactly one `done`; `tx` frame unchanged.
- **`resetn` low at cycle 20 mid-frame** → same cycle: `ss`=1, `sclk`=0, `mosi`=0, `ready`=1; no `done`. The next frame then completes correctly.
- **`start` held high, `CLK_DIV`=1 and 2** → consecutive frames, `ss`-high gap equal to CLK_DIV+1 cycles, one `done` per frame.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI master types, defaults and bridge frame fields
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } spi_state_t;

    localparam int SPI_FRAME_WIDTH = 16;

    // Bridge frame layout: R/W flag, 7-bit register address, 8-bit data
    localparam int RW_BIT   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - per-state divider counter producing the expire tick
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    output logic expire
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // Count system clocks spent in the current state; restart on every state change
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = (cnt == LAST);

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode 0 SPI master shifting one fixed-width frame MSB first
module spi_master
    import spi_pkg::*;
#(
    parameter int FRAME_WIDTH = SPI_FRAME_WIDTH,
    parameter int CLK_DIV     = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [FRAME_WIDTH-1:0] tx_data,
    output logic                   ready,
    output logic                   done,
    output logic [FRAME_WIDTH-1:0] rx_data,
    output logic                   sclk,
    output logic                   ss,
    output logic                   mosi,
    input  logic                   miso
);

    localparam int BW = $clog2(FRAME_WIDTH) + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_WIDTH - 1);

    spi_state_t state, state_next;

    logic                   expire;
    logic                   div_clear;
    logic [FRAME_WIDTH-1:0] tx_sh;
    logic [FRAME_WIDTH-1:0] rx_sh;
    logic [BW-1:0]          bit_cnt;
    logic                   do_load, do_rise, do_fall, do_finish, do_release;

    // The divider restarts whenever the state changes and is held at zero while idle
    assign div_clear = (state_next != state) || (state == IDLE);

    // mosi comes straight from the tx shift register MSB, which is cleared outside a frame
    assign mosi = tx_sh[FRAME_WIDTH-1];

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk    (clk),
        .resetn (resetn),
        .clear  (div_clear),
        .expire (expire)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and one-cycle action strobes for the datapath
    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_rise    = 1'b0;
        do_fall    = 1'b0;
        do_finish  = 1'b0;
        do_release = 1'b0;
        case (state)
            IDLE: begin
                if (start && ready) begin
                    do_load    = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP, LOW: begin
                if (expire) begin
                    do_rise    = 1'b1;
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (expire) begin
                    do_fall    = 1'b1;
                    state_next = (bit_cnt == LAST_BIT) ? HOLD : LOW;
                end
            end
            HOLD: begin
                if (expire) begin
                    do_finish  = 1'b1;
                    state_next = GAP;
                end
            end
            GAP: begin
                if (expire) begin
                    do_release = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift registers, bit counter and registered SPI/handshake outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_sh   <= '0;
            rx_sh   <= '0;
            bit_cnt <= '0;
            rx_data <= '0;
            ready   <= 1'b1;
            done    <= 1'b0;
            sclk    <= 1'b0;
            ss      <= 1'b1;
        end else begin
            done <= do_finish;
            if (do_load) begin
                tx_sh   <= tx_data;
                ss      <= 1'b0;
                ready   <= 1'b0;
                bit_cnt <= '0;
            end
            if (do_rise) begin
                sclk  <= 1'b1;
                rx_sh <= {rx_sh[FRAME_WIDTH-2:0], miso};
            end
            if (do_fall) begin
                sclk    <= 1'b0;
                bit_cnt <= bit_cnt + 1'b1;
                // The last bit stays on mosi through HOLD
                if (bit_cnt != LAST_BIT) begin
                    tx_sh <= {tx_sh[FRAME_WIDTH-2:0], 1'b0};
                end
            end
            if (do_finish) begin
                ss      <= 1'b1;
                tx_sh   <= '0;
                rx_data <= rx_sh;
            end
            if (do_release) begin
                ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed self-checking bench for spi_master
module tb_spi_master;

    localparam int DIV = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start, start1;
    logic [15:0] tx_data, tx_data1;
    logic        ready, ready1;
    logic        done, done1;
    logic [15:0] rx_data, rx_data1;
    logic        sclk, sclk1;
    logic        ss, ss1;
    logic        mosi, mosi1;
    logic        miso;
    logic        miso_drv;
    logic [1:0]  mode;

    int checks = 0;
    int errors = 0;

    int          f_lat, f_rdy, f_dones, f_rises, f_mosi1, f_viol;
    logic [15:0] f_rx;
    logic [3:0]  f_rst_snap;
    int          pulse_at, reset_at;
    logic [15:0] slave_sh;

    always #5 clk = ~clk;

    // mode 0: loopback, 1: tied low, 2: slave model shifting on sclk fall
    assign miso = (mode == 2'd0) ? mosi : miso_drv;

    spi_master #(.FRAME_WIDTH(16), .CLK_DIV(DIV)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .tx_data (tx_data),
        .ready   (ready),
        .done    (done),
        .rx_data (rx_data),
        .sclk    (sclk),
        .ss      (ss),
        .mosi    (mosi),
        .miso    (miso)
    );

    spi_master #(.FRAME_WIDTH(16), .CLK_DIV(1)) dut1 (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start1),
        .tx_data (tx_data1),
        .ready   (ready1),
        .done    (done1),
        .rx_data (rx_data1),
        .sclk    (sclk1),
        .ss      (ss1),
        .mosi    (mosi1),
        .miso    (mosi1)
    );

    // Launch one frame on dut and observe it cycle by cycle; k is the edge count from acceptance
    task automatic run_frame(input logic [15:0] d);
        int   last_rise, last_mchg;
        logic prev_sclk, prev_mosi;
        f_lat = -1; f_rdy = -1; f_dones = 0; f_rises = 0; f_mosi1 = 0; f_viol = 0;
        f_rx = '0; f_rst_snap = '0;
        @(negedge clk);
        start = 1'b1; tx_data = d;
        if (mode == 2'd2) miso_drv = slave_sh[15];
        @(negedge clk);
        start = 1'b0; tx_data = ~d;
        prev_sclk = sclk; prev_mosi = mosi; last_rise = -100; last_mchg = 0;
        for (int k = 0; k < 400; k++) begin
            if (k > 0) @(negedge clk);
            start = (k == pulse_at);
            if (k == reset_at) begin
                resetn = 1'b0;
                #1;
                f_rst_snap = {ss, sclk, mosi, ready};
            end
            if (k == reset_at + 3) resetn = 1'b1;
            if (sclk && !prev_sclk) begin
                f_rises++;
                if (mosi) f_mosi1++;
                if (k - last_mchg < DIV) f_viol++;
                last_rise = k;
            end
            if (!sclk && prev_sclk && mode == 2'd2) begin
                slave_sh = {slave_sh[14:0], 1'b0};
                miso_drv = slave_sh[15];
            end
            if (mosi !== prev_mosi) begin
                if (k - last_rise < DIV) f_viol++;
                last_mchg = k;
            end
            if (done) begin
                f_dones++;
                if (f_lat < 0) begin
                    f_lat = k;
                    f_rx  = rx_data;
                end
            end
            if (f_lat >= 0 && ready && f_rdy < 0) f_rdy = k;
            prev_sclk = sclk; prev_mosi = mosi;
            if (f_rdy >= 0 && k >= f_rdy + 4) break;
            if (reset_at >= 0 && k >= reset_at + 10) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ready !== 1'b1)    begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (rx_data !== 16'h0) begin errors++; $display("FAIL reset_rx_data: got %h expected 0000", rx_data); end
        checks++; if (sclk !== 1'b0)     begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
        checks++; if (ss !== 1'b1)       begin errors++; $display("FAIL reset_ss: got %b expected 1", ss); end
        checks++; if (mosi !== 1'b0)     begin errors++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
        checks++; if (ready1 !== 1'b1)   begin errors++; $display("FAIL reset_ready_div1: got %b expected 1", ready1); end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loopback();
        mode = 2'd0;
        run_frame(16'hA5C3);
        checks++; if (f_rx !== 16'hA5C3)  begin errors++; $display("FAIL loop_rx: got %h expected a5c3", f_rx); end
        checks++; if (f_lat != 66)        begin errors++; $display("FAIL loop_done_latency: got %0d expected 66", f_lat); end
        checks++; if (f_rises != 16)      begin errors++; $display("FAIL loop_sclk_rises: got %0d expected 16", f_rises); end
        checks++; if (f_rdy - f_lat != 2) begin errors++; $display("FAIL loop_ready_after_done: got %0d expected 2", f_rdy - f_lat); end
        checks++; if (f_dones != 1)       begin errors++; $display("FAIL loop_done_count: got %0d expected 1", f_dones); end
    endtask

    task automatic test_miso_zero();
        mode = 2'd1; miso_drv = 1'b0;
        run_frame(16'hFFFF);
        checks++; if (f_rx !== 16'h0000) begin errors++; $display("FAIL zero_rx: got %h expected 0000", f_rx); end
        checks++; if (f_mosi1 != 16)     begin errors++; $display("FAIL zero_mosi_high_at_rise: got %0d expected 16", f_mosi1); end
    endtask

    task automatic test_slave();
        mode = 2'd2; slave_sh = 16'h3C5A;
        run_frame(16'h9A61);
        checks++; if (f_rx !== 16'h3C5A) begin errors++; $display("FAIL slave_rx: got %h expected 3c5a", f_rx); end
        checks++; if (f_viol != 0)       begin errors++; $display("FAIL slave_mosi_setup_hold: got %0d violations expected 0", f_viol); end
        checks++; if (f_rises != 16)     begin errors++; $display("FAIL slave_sclk_rises: got %0d expected 16", f_rises); end
    endtask

    task automatic test_ignored_start();
        mode = 2'd0; pulse_at = 10;
        run_frame(16'h5A0F);
        pulse_at = -1;
        checks++; if (f_dones != 1)      begin errors++; $display("FAIL busy_start_done_count: got %0d expected 1", f_dones); end
        checks++; if (f_rx !== 16'h5A0F) begin errors++; $display("FAIL busy_start_rx: got %h expected 5a0f", f_rx); end
        checks++; if (ss !== 1'b1)       begin errors++; $display("FAIL busy_start_not_queued_ss: got %b expected 1", ss); end
    endtask

    task automatic test_reset_mid_frame();
        mode = 2'd0; reset_at = 20;
        run_frame(16'hC0DE);
        reset_at = -1;
        checks++; if (f_rst_snap !== 4'b1001) begin errors++; $display("FAIL midreset_outputs {ss,sclk,mosi,ready}: got %b expected 1001", f_rst_snap); end
        checks++; if (f_dones != 0)           begin errors++; $display("FAIL midreset_no_done: got %0d expected 0", f_dones); end
        checks++; if (rx_data !== 16'h0)      begin errors++; $display("FAIL midreset_rx_cleared: got %h expected 0000", rx_data); end
        run_frame(16'h1234);
        checks++; if (f_rx !== 16'h1234) begin errors++; $display("FAIL after_reset_rx: got %h expected 1234", f_rx); end
        checks++; if (f_lat != 66)       begin errors++; $display("FAIL after_reset_latency: got %0d expected 66", f_lat); end
    endtask

    task automatic test_back_to_back();
        int   hi0, hi1, gaps0, gaps1, bad0, bad1, dn0, dn1;
        logic seen0, seen1;
        hi0 = 0; hi1 = 0; gaps0 = 0; gaps1 = 0; bad0 = 0; bad1 = 0; dn0 = 0; dn1 = 0;
        seen0 = 1'b0; seen1 = 1'b0;
        mode = 2'd0;
        @(negedge clk);
        start = 1'b1; start1 = 1'b1; tx_data = 16'hB00C; tx_data1 = 16'h7E81;
        for (int k = 0; k < 300; k++) begin
            if (k > 0) @(negedge clk);
            start  = (k < 211);
            start1 = (k < 211);
            if (ss) hi0++;
            else begin
                if (seen0 && hi0 > 0) begin gaps0++; if (hi0 != DIV + 1) bad0++; end
                seen0 = 1'b1; hi0 = 0;
            end
            if (ss1) hi1++;
            else begin
                if (seen1 && hi1 > 0) begin gaps1++; if (hi1 != 2) bad1++; end
                seen1 = 1'b1; hi1 = 0;
            end
            if (done)  begin dn0++; if (rx_data  !== 16'hB00C) bad0++; end
            if (done1) begin dn1++; if (rx_data1 !== 16'h7E81) bad1++; end
        end
        start = 1'b0; start1 = 1'b0;
        checks++; if (dn0 != 4)   begin errors++; $display("FAIL b2b_div2_dones: got %0d expected 4", dn0); end
        checks++; if (gaps0 != 3) begin errors++; $display("FAIL b2b_div2_gaps: got %0d expected 3", gaps0); end
        checks++; if (bad0 != 0)  begin errors++; $display("FAIL b2b_div2_gap_or_rx: got %0d bad expected 0", bad0); end
        checks++; if (dn1 != 7)   begin errors++; $display("FAIL b2b_div1_dones: got %0d expected 7", dn1); end
        checks++; if (gaps1 != 6) begin errors++; $display("FAIL b2b_div1_gaps: got %0d expected 6", gaps1); end
        checks++; if (bad1 != 0)  begin errors++; $display("FAIL b2b_div1_gap_or_rx: got %0d bad expected 0", bad1); end
    endtask

    initial begin
        start = 1'b0; start1 = 1'b0; tx_data = '0; tx_data1 = '0;
        mode = 2'd0; miso_drv = 1'b0; slave_sh = '0;
        pulse_at = -1; reset_at = -1;
        test_reset();
        test_loopback();
        test_miso_zero();
        test_slave();
        test_ignored_start();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
